conv_window_seq: RTL and testbench

Sequencer and multiplier stage directly upstream of the convolution accumulator. It sweeps every valid K×K window of a W×W input feature map in row-major order. For each tap it fetches one pixel and one weight from synchronous-read memories, multiplies them, and rescales the fixed-point product to 8 bits. It emits the scaled product (`sum`), the output coordinates (`i`, `j`), the accumulate strobe (`acc_enable`) and the end-of-window strobe (`flush_acc`) consumed by the accumulator.

---
 rtl/conv_window_if.sv | 33 +++
 rtl/conv_window_seq.sv | 191 +++++++++++++++++++
 tb/tb_conv_window_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_if.sv
// conv_window_if: handshake and memory-port bundle for conv_window_seq.
//   start            pass request (driver -> sequencer)
//   busy, done       pass status
//   img_addr/w_addr  synchronous-read memory addresses
//   img_data/w_data  memory read data, valid one cycle after the address
//   sum, i, j        scaled tap product and window coordinates
//   acc_enable       accumulate strobe
//   flush_acc        end-of-window strobe
// Modports: master = driver/memories/accumulator side, slave = sequencer.
interface conv_window_if;
    logic              start;
    logic              busy;
    logic              done;
    logic [9:0]        img_addr;
    logic signed [7:0] img_data;
    logic [3:0]        w_addr;
    logic signed [7:0] w_data;
    logic signed [7:0] sum;
    logic [4:0]        i;
    logic [4:0]        j;
    logic              acc_enable;
    logic              flush_acc;

    modport master (
        output start, img_data, w_data,
        input  busy, done, img_addr, w_addr, sum, i, j, acc_enable, flush_acc
    );

    modport slave (
        input  start, img_data, w_data,
        output busy, done, img_addr, w_addr, sum, i, j, acc_enable, flush_acc
    );
endinterface

// File: rtl/conv_window_seq.sv
// conv_window_seq: sweeps every KxK window of a WxW map in row-major order,
// fetches pixel/weight per tap, multiplies and rescales the product to 8 bits
// for the downstream accumulator.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   conv_window_if.slave (start/busy/done, memory ports, sum/i/j,
//         acc_enable/flush_acc)
// Build option: define CONV_SAT_EN to saturate the scaled product to
// [-128,127]; otherwise it wraps to its low 8 bits.
module conv_window_seq #(
    parameter int W    = 28,
    parameter int K    = 3,
    parameter int FRAC = 6
) (
    input  logic         clk,
    input  logic         rst,
    conv_window_if.slave bus
);
    localparam int LAST = W - K;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef struct packed {
        logic       valid;
        logic       flush;
        logic [4:0] i;
        logic [4:0] j;
    } tag_t;

    logic [1:0] state;
    logic       drain_cnt;

    // Slot currently presented in stage 0.
    logic [4:0] ci, cj;
    logic [1:0] ki, kj;
    logic       bub;

    logic [4:0] n_ci, n_cj;
    logic [1:0] n_ki, n_kj;
    logic       n_bub;
    logic       last_slot;
    logic       issue;

    logic [9:0] img_addr_n;
    logic [3:0] w_addr_n;
    logic [9:0] img_addr_q;
    logic [3:0] w_addr_q;

    tag_t tag0, tag1;

    logic signed [15:0] prod;
    logic signed [7:0]  s8;
    logic signed [7:0]  sum_q;
    logic               acc_q, flush_q;
    logic [4:0]         i_q, j_q;

    // Next issue slot: taps kj inner / ki outer, then one bubble, then the
    // next window (j inner, i outer). IDLE always points at the first tap.
    always_comb begin
        n_ci  = ci;
        n_cj  = cj;
        n_ki  = ki;
        n_kj  = kj;
        n_bub = bub;
        if (state == S_IDLE) begin
            n_ci  = '0;
            n_cj  = '0;
            n_ki  = '0;
            n_kj  = '0;
            n_bub = 1'b0;
        end else if (bub) begin
            n_bub = 1'b0;
            n_ki  = '0;
            n_kj  = '0;
            if (cj == 5'(LAST)) begin
                n_cj = '0;
                n_ci = ci + 5'd1;
            end else begin
                n_cj = cj + 5'd1;
            end
        end else if (kj == 2'(K - 1)) begin
            n_kj = '0;
            if (ki == 2'(K - 1))
                n_bub = 1'b1;
            else
                n_ki = ki + 2'd1;
        end else begin
            n_kj = kj + 2'd1;
        end
    end

    assign last_slot  = bub && (ci == 5'(LAST)) && (cj == 5'(LAST));
    assign issue      = ((state == S_IDLE) && bus.start) ||
                        ((state == S_RUN) && !last_slot);
    assign img_addr_n = 10'((int'(n_ci) + int'(n_ki)) * W + int'(n_cj) + int'(n_kj));
    assign w_addr_n   = 4'(int'(n_ki) * K + int'(n_kj));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            drain_cnt  <= 1'b0;
            ci         <= '0;
            cj         <= '0;
            ki         <= '0;
            kj         <= '0;
            bub        <= 1'b0;
            tag0       <= '0;
            img_addr_q <= '0;
            w_addr_q   <= '0;
        end else begin
            case (state)
                S_IDLE:  if (bus.start) state <= S_RUN;
                S_RUN:   if (last_slot) begin
                             state     <= S_DRAIN;
                             drain_cnt <= 1'b0;
                         end
                S_DRAIN: begin
                             drain_cnt <= 1'b1;
                             if (drain_cnt) state <= S_DONE;
                         end
                default: state <= S_IDLE;
            endcase

            if (issue) begin
                ci   <= n_ci;
                cj   <= n_cj;
                ki   <= n_ki;
                kj   <= n_kj;
                bub  <= n_bub;
                tag0 <= '{valid: !n_bub, flush: n_bub, i: n_ci, j: n_cj};
                // Bubble issues no read, so the addresses simply hold.
                if (!n_bub) begin
                    img_addr_q <= img_addr_n;
                    w_addr_q   <= w_addr_n;
                end
            end else begin
                tag0 <= '0;
            end
        end
    end

    // Product and rescale on the data returned for the stage-1 slot.
    assign prod = bus.img_data * bus.w_data;

`ifdef CONV_SAT_EN
    logic signed [15:0] shifted;
    assign shifted = prod >>> FRAC;
    always_comb begin
        if (shifted > 16'sd127)
            s8 = 8'sd127;
        else if (shifted < -16'sd128)
            s8 = -8'sd128;
        else
            s8 = shifted[7:0];
    end
`else
    assign s8 = 8'(prod >>> FRAC);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tag1    <= '0;
            sum_q   <= '0;
            acc_q   <= 1'b0;
            flush_q <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            tag1    <= tag0;
            sum_q   <= s8;
            acc_q   <= tag1.valid;
            flush_q <= tag1.flush;
            i_q     <= tag1.i;
            j_q     <= tag1.j;
        end
    end

    assign bus.busy       = (state == S_RUN) || (state == S_DRAIN);
    assign bus.done       = (state == S_DONE);
    assign bus.img_addr   = img_addr_q;
    assign bus.w_addr     = w_addr_q;
    assign bus.sum        = sum_q;
    assign bus.acc_enable = acc_q;
    assign bus.flush_acc  = flush_q;
    assign bus.i          = i_q;
    assign bus.j          = j_q;
endmodule

// File: tb/tb_conv_window_seq.sv
// tb_conv_window_seq: randomized self-checking bench for conv_window_seq.
// Expected strobe/sum/coordinate/address stream is generated per pass from
// the window-sweep rules over the memory contents; timing offsets are
// derived from the map/kernel sizes. Honours CONV_SAT_EN like the design.
module tb_conv_window_seq;
    localparam int W    = 28;
    localparam int K    = 3;
    localparam int FRAC = 6;
    localparam int NW   = W - K + 1;
    localparam int DONE_OFS  = NW * NW * (K * K + 1) + 3;
    localparam int FIRST_OFS = 3;

    typedef struct {
        bit flush;
        int i;
        int j;
        int sum;
        int ia;
        int wa;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    conv_window_if bus ();

    conv_window_seq #(.W(W), .K(K), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [7:0] img_mem [0:1023];
    logic signed [7:0] w_mem   [0:15];

    // Synchronous-read memories.
    always @(posedge clk) begin
        bus.img_data <= img_mem[bus.img_addr];
        bus.w_data   <= w_mem[bus.w_addr];
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    bit   mon_on;
    int   first_acc_cyc, done_cyc, busy_at_done;
    int   n_acc, n_flush, max_ia, nsum;
    int   first_sum [2];
    int   ia_h1, ia_h2, wa_h1, wa_h2;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int ref_scale(input int p);
        int d, f, r;
        d = 1 << FRAC;
        f = (p >= 0) ? p / d : -((-p + d - 1) / d);
`ifdef CONV_SAT_EN
        r = (f > 127) ? 127 : ((f < -128) ? -128 : f);
`else
        r = ((f % 256) + 256) % 256;
        if (r > 127) r -= 256;
`endif
        return r;
    endfunction

    task automatic build_model();
        exp_t e;
        q.delete();
        for (int wi = 0; wi < NW; wi++)
            for (int wj = 0; wj < NW; wj++) begin
                for (int a = 0; a < K; a++)
                    for (int b = 0; b < K; b++) begin
                        e.flush = 1'b0;
                        e.i     = wi;
                        e.j     = wj;
                        e.ia    = (wi + a) * W + wj + b;
                        e.wa    = a * K + b;
                        e.sum   = ref_scale(int'(img_mem[e.ia]) * int'(w_mem[e.wa]));
                        q.push_back(e);
                    end
                e.flush = 1'b1;
                e.i     = wi;
                e.j     = wj;
                e.sum   = 0;
                e.ia    = 0;
                e.wa    = 0;
                q.push_back(e);
            end
    endtask

    task automatic clear_stats();
        first_acc_cyc = -1;
        done_cyc      = -1;
        busy_at_done  = -1;
        n_acc         = 0;
        n_flush       = 0;
        max_ia        = -1;
        nsum          = 0;
        first_sum[0]  = 999;
        first_sum[1]  = 999;
    endtask

    // Output monitor, sampled mid-cycle; address history lines up each tap
    // with the address issued two cycles before its acc_enable.
    task automatic sample();
        exp_t e;
        if (mon_on) begin
            if (bus.acc_enable || bus.flush_acc) begin
                chk("strobe_overlap", int'(bus.acc_enable && bus.flush_acc), 0);
                if (q.size() == 0) begin
                    chk("extra_strobe", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("flush_kind", int'(bus.flush_acc), int'(e.flush));
                    chk("i", int'(bus.i), e.i);
                    chk("j", int'(bus.j), e.j);
                    if (!e.flush) begin
                        chk("sum", int'(bus.sum), e.sum);
                        chk("img_addr", ia_h2, e.ia);
                        chk("w_addr", wa_h2, e.wa);
                    end
                end
                if (bus.acc_enable) begin
                    n_acc++;
                    if (first_acc_cyc < 0) first_acc_cyc = cyc;
                    if (ia_h2 > max_ia) max_ia = ia_h2;
                    if (nsum < 2) begin
                        first_sum[nsum] = int'(bus.sum);
                        nsum++;
                    end
                end
                if (bus.flush_acc) n_flush++;
            end
            if (bus.done && done_cyc < 0) begin
                done_cyc     = cyc;
                busy_at_done = int'(bus.busy);
            end
        end
        ia_h2 = ia_h1;
        wa_h2 = wa_h1;
        ia_h1 = int'(bus.img_addr);
        wa_h1 = int'(bus.w_addr);
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
    endtask

    // Called on a negedge while IDLE: start is sampled at the next edge.
    task automatic launch(output int t);
        build_model();
        clear_stats();
        mon_on    = 1'b1;
        bus.start = 1'b1;
        t         = cyc;
    endtask

    task automatic wait_done(input int t);
        while (done_cyc < 0 && cyc < t + DONE_OFS + 50) tick();
    endtask

    task automatic end_checks(input int t);
        chk("first_acc_ofs", first_acc_cyc - t, FIRST_OFS);
        chk("done_ofs", done_cyc - t, DONE_OFS);
        chk("busy_at_done", busy_at_done, 0);
        chk("n_flush", n_flush, NW * NW);
        chk("n_acc", n_acc, NW * NW * K * K);
        chk("model_left", q.size(), 0);
        chk("max_img_addr", max_ia, (W - 1) * W + (W - 1));
    endtask

    task automatic fill_random();
        for (int a = 0; a < 1024; a++) img_mem[a] = 8'($urandom_range(0, 255));
        for (int a = 0; a < 16; a++)   w_mem[a]   = 8'($urandom_range(0, 255));
    endtask

    int t, t2;

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        mon_on    = 1'b0;
        ia_h1 = 0; ia_h2 = 0; wa_h1 = 0; wa_h2 = 0;
        clear_stats();
        for (int a = 0; a < 1024; a++) img_mem[a] = 8'sd0;
        for (int a = 0; a < 16; a++)   w_mem[a]   = 8'sd0;

        // Reset state.
        repeat (2) tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_acc", int'(bus.acc_enable), 0);
        chk("rst_flush", int'(bus.flush_acc), 0);
        chk("rst_sum", int'(bus.sum), 0);
        chk("rst_img_addr", int'(bus.img_addr), 0);
        chk("rst_w_addr", int'(bus.w_addr), 0);
        chk("rst_ij", int'({bus.i, bus.j}), 0);
        rst = 1'b0;
        tick();

        // Unity data: every product 64*64 >>> 6 = 64.
        for (int a = 0; a < 1024; a++) img_mem[a] = 8'sd64;
        for (int a = 0; a < 16; a++)   w_mem[a]   = 8'sd64;
        launch(t);
        tick();
        chk("busy_t1", int'(bus.busy), 1);
        bus.start = 1'b0;
        wait_done(t);
        end_checks(t);
        chk("unity_sum", first_sum[0], 64);
        while (cyc < t + DONE_OFS + 1) tick();
        chk("idle_after_done", int'(bus.busy | bus.done), 0);
        repeat (3) tick();

        // Random data, start re-asserted mid-pass and held through done.
        fill_random();
        launch(t);
        tick();
        bus.start = 1'b0;
        while (cyc < t + 50) tick();
        bus.start = 1'b1;
        wait_done(t);
        end_checks(t);
        build_model();
        clear_stats();
        while (cyc < t + DONE_OFS + 1) tick();
        chk("held_start_idle", int'(bus.busy), 0);
        t2 = cyc;
        tick();
        chk("retrigger_busy", int'(bus.busy), 1);
        chk("retrigger_addr", int'(bus.img_addr), 0);
        bus.start = 1'b0;

        // Mid-pass reset on the re-triggered pass.
        while (cyc < t2 + 100) tick();
        rst    = 1'b1;
        mon_on = 1'b0;
        tick();
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_acc", int'(bus.acc_enable), 0);
        chk("midrst_flush", int'(bus.flush_acc), 0);
        chk("midrst_done", int'(bus.done), 0);
        rst = 1'b0;
        repeat (20) begin
            tick();
            chk("midrst_quiet", int'(bus.acc_enable | bus.flush_acc | bus.done | bus.busy), 0);
        end

        // Fresh pass after reset, with saturation corner taps first.
        fill_random();
        img_mem[0] = 8'sd127;
        img_mem[1] = -8'sd128;
        w_mem[0]   = 8'sd127;
        w_mem[1]   = 8'sd127;
        launch(t);
        tick();
        chk("restart_img_addr", int'(bus.img_addr), 0);
        chk("restart_w_addr", int'(bus.w_addr), 0);
        bus.start = 1'b0;
        wait_done(t);
        end_checks(t);
`ifdef CONV_SAT_EN
        chk("sat_pos", first_sum[0], 127);
        chk("sat_neg", first_sum[1], -128);
`else
        chk("wrap_pos", first_sum[0], -4);
        chk("wrap_neg", first_sum[1], 2);
`endif
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
